// File: rtl/block_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : block_accumulator_if
// Description : Bundles the signals that connect block_accumulator to its
//               producer and consumer.
//               Producer side : ce, in_valid, y, flush
//               Consumer side : out_data, out_len, out_valid, out_ready
//               Status        : drop, ovf
//               master modport = the environment that drives the block.
//               slave modport  = block_accumulator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface block_accumulator_if #(
  parameter int IN_W  = 21,
  parameter int ACC_W = 32
);
  logic                    ce;
  logic                    in_valid;
  logic signed [IN_W-1:0]  y;
  logic                    flush;
  logic signed [ACC_W-1:0] out_data;
  logic [7:0]              out_len;
  logic                    out_valid;
  logic                    out_ready;
  logic                    drop;
  logic                    ovf;

  modport master (
    output ce, in_valid, y, flush, out_ready,
    input  out_data, out_len, out_valid, drop, ovf
  );

  modport slave (
    input  ce, in_valid, y, flush, out_ready,
    output out_data, out_len, out_valid, drop, ovf
  );
endinterface
`default_nettype wire

// File: rtl/block_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : block_accumulator
// Description : Sums BLOCK_LEN consecutive signed products from the (A+B)*C
//               stage into one ACC_W-bit block sum. in_valid is re-aligned
//               to the stage latency by a ce-qualified delay line. Finished
//               sums go through a 2-entry FIFO drained by valid/ready.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               bus.slave  - ce, in_valid, y, flush (in);
//                            out_data, out_len, out_valid (out);
//                            out_ready (in); drop, ovf (sticky status out)
// Options     : BLOCK_ACC_SATURATE_EN - when defined the accumulator clamps
//               on overflow; otherwise it wraps. ovf is set either way.
// Revision    : 1.0 - initial release
// ============================================================================
module block_accumulator #(
  parameter int IN_W      = 21,
  parameter int ACC_W     = 32,
  parameter int BLOCK_LEN = 16,
  parameter int LATENCY   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  block_accumulator_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [7:0] c_block_len = 8'(BLOCK_LEN);

  state_t                  r_state;
  logic [LATENCY-1:0]      r_vpipe;
  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_cnt;
  logic                    r_ovf;
  logic                    r_drop;

  logic signed [ACC_W-1:0] r_fifo_data [2];
  logic [7:0]              r_fifo_len  [2];
  logic                    r_wptr;
  logic                    r_rptr;
  logic [1:0]              r_count;

  logic                    w_vd;
  logic                    w_take;
  logic signed [ACC_W-1:0] w_y_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_ovf;
  logic [7:0]              w_cnt_next;
  logic                    w_push;
  logic signed [ACC_W-1:0] w_push_data;
  logic [7:0]              w_push_len;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_wr;

  // --------------------------------------------------------------------------
  // Valid delay line: mirrors the arithmetic stage pipeline, so it only moves
  // when the stage does (ce=1).
  // --------------------------------------------------------------------------
  generate
    if (LATENCY == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_vpipe <= '0;
        else if (bus.ce) r_vpipe <= bus.in_valid;
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_vpipe <= '0;
        else if (bus.ce) r_vpipe <= {r_vpipe[LATENCY-2:0], bus.in_valid};
      end
    end
  endgenerate

  assign w_vd   = r_vpipe[LATENCY-1];
  assign w_take = bus.ce & w_vd;

  // --------------------------------------------------------------------------
  // Adder with sign-based overflow detection. In IDLE the accumulator is
  // already zero, so acc + y equals the sign-extended first sample.
  // --------------------------------------------------------------------------
  assign w_y_ext = ACC_W'(bus.y);
  assign w_sum   = r_acc + w_y_ext;
  assign w_ovf   = (r_acc[ACC_W-1] == w_y_ext[ACC_W-1]) &&
                   (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef BLOCK_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  // Both operands share a sign on overflow, so the accumulator sign picks
  // the rail.
  assign w_acc_next = !w_ovf ? w_sum : (r_acc[ACC_W-1] ? c_acc_min : c_acc_max);
`else
  assign w_acc_next = w_sum;
`endif

  assign w_cnt_next = r_cnt + 8'd1;

  // A block closes on its last sample, or on flush when there is anything
  // to emit (a running block or a sample arriving in the same cycle).
  assign w_push = (w_take && (w_cnt_next == c_block_len)) ||
                  (bus.ce && bus.flush && (w_take || (r_state == ACCUM)));
  assign w_push_data = w_take ? w_acc_next : r_acc;
  assign w_push_len  = w_take ? w_cnt_next : r_cnt;

  // --------------------------------------------------------------------------
  // Accumulator state machine; frozen while ce=0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.ce) begin
      if (w_take && w_ovf) r_ovf <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_take && !w_push) begin
            r_state <= ACCUM;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
          end
        end
        ACCUM: begin
          if (w_push) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else if (w_take) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry output FIFO, runs regardless of ce. A push into a full FIFO
  // succeeds only if the head leaves in the same cycle; the write then lands
  // in the slot being vacated.
  // --------------------------------------------------------------------------
  assign w_full = (r_count == 2'd2);
  assign w_pop  = (r_count != 2'd0) && bus.out_ready;
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_len[0]  <= '0;
      r_fifo_len[1]  <= '0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_count        <= 2'd0;
      r_drop         <= 1'b0;
    end else begin
      if (w_wr) begin
        r_fifo_data[r_wptr] <= w_push_data;
        r_fifo_len[r_wptr]  <= w_push_len;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_drop <= 1'b1;
    end
  end

  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = bus.out_valid ? r_fifo_data[r_rptr] : '0;
  assign bus.out_len   = bus.out_valid ? r_fifo_len[r_rptr]  : '0;
  assign bus.drop      = r_drop;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_accumulator
// Description : Self-checking bench for block_accumulator. Models the
//               upstream arithmetic stage as a ce-advanced product pipeline,
//               keeps a reference block-sum model and compares every drained
//               output against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_accumulator;

  localparam int IN_W = 21;
  localparam int ACC_W = 22;
  localparam int BL = 4;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  block_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .BLOCK_LEN(BL), .LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  longint exp_data[$];
  int     exp_len[$];

  // upstream stage pipeline model
  bit                     pv[LAT];
  logic signed [IN_W-1:0] py[LAT];

  longint m_sum = 0;
  int     m_cnt = 0;
  bit     skip_push = 1'b0;

  longint mon_d;
  int     mon_l;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint madd(input longint a, input longint b);
    longint one = 1;
    longint mx = (one << (ACC_W-1)) - 1;
    longint mn = -(one << (ACC_W-1));
    longint s = a + b;
`ifdef BLOCK_ACC_SATURATE_EN
    if (s > mx) return mx;
    if (s < mn) return mn;
`else
    if (s > mx) return s - (one << ACC_W);
    if (s < mn) return s + (one << ACC_W);
`endif
    return s;
  endfunction

  task automatic mpush(input longint d, input int l);
    if (skip_push) skip_push = 1'b0;
    else begin
      exp_data.push_back(d);
      exp_len.push_back(l);
    end
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input bit c, input bit iv, input longint p, input bit fl);
    bus.ce = c;
    bus.in_valid = iv;
    bus.flush = fl;
    if (pv[LAT-1]) bus.y = py[LAT-1];
    else bus.y = IN_W'($urandom);
    if (c) begin
      if (pv[LAT-1]) begin
        m_sum = (m_cnt == 0) ? longint'(py[LAT-1]) : madd(m_sum, py[LAT-1]);
        m_cnt++;
      end
      if ((pv[LAT-1] && m_cnt == BL) || (fl && m_cnt > 0)) begin
        mpush(m_sum, m_cnt);
        m_sum = 0;
        m_cnt = 0;
      end
      for (int i = LAT-1; i > 0; i--) begin
        pv[i] = pv[i-1];
        py[i] = py[i-1];
      end
      pv[0] = iv;
      py[0] = IN_W'(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_data.size() > 0; i++) idle(1);
    check_eq("drain_empty", exp_data.size(), 0);
  endtask

  task automatic blk(input longint base);
    for (int j = 0; j < BL; j++) cyc(1'b1, 1'b1, base + j, 1'b0);
    idle(LAT);
  endtask

  // Scoreboard: compare every accepted output against the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_data.size() == 0) check_eq("unexpected_out", bus.out_data, 0);
      else begin
        mon_d = exp_data.pop_front();
        mon_l = exp_len.pop_front();
        check_eq("out_data", bus.out_data, mon_d);
        check_eq("out_len", bus.out_len, mon_l);
      end
    end
  end

  initial begin
    bus.ce = 1'b0;
    bus.in_valid = 1'b0;
    bus.y = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      py[i] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_data", bus.out_data, 0);
    check_eq("rst_len", bus.out_len, 0);
    check_eq("rst_drop", bus.drop, 0);
    check_eq("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic block; output one clk after the last sample's ce cycle
    cyc(1, 1, 100, 0);
    cyc(1, 1, -30, 0);
    cyc(1, 1, 7, 0);
    cyc(1, 1, 1000, 0);
    idle(LAT - 1);
    check_eq("lat_not_early", bus.out_valid, 0);
    idle(1);
    check_eq("lat_valid", bus.out_valid, 1);
    check_eq("basic_sum", bus.out_data, 1077);
    check_eq("basic_len", bus.out_len, 4);
    idle(1);
    check_eq("basic_pulse", bus.out_valid, 0);
    check_eq("basic_drop", bus.drop, 0);
    check_eq("basic_ovf", bus.ovf, 0);

    // ce toggling; in_valid and flush asserted in ce=0 cycles must be ignored
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1'($urandom_range(1)), longint'($urandom_range(10000)) - 5000, 0);
      cyc(0, 1, longint'($urandom_range(10000)), 1);
    end
    repeat (LAT + 1) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 1);
    end
    cyc(1, 0, 0, 1);
    drain();

    // flush with a same-cycle 4th sample
    cyc(1, 1, 5, 0);
    cyc(1, 1, 5, 0);
    cyc(1, 1, -2, 0);
    cyc(1, 1, 9, 0);
    idle(LAT - 1);
    cyc(1, 0, 0, 1);
    check_eq("flush4_sum", bus.out_data, 17);
    check_eq("flush4_len", bus.out_len, 4);
    drain();

    // flush alone in ACCUM after 2 samples
    cyc(1, 1, 3, 0);
    cyc(1, 1, 4, 0);
    idle(LAT);
    cyc(1, 0, 0, 1);
    check_eq("flush2_sum", bus.out_data, 7);
    check_eq("flush2_len", bus.out_len, 2);
    drain();

    // flush in IDLE with no sample: nothing
    cyc(1, 0, 0, 1);
    idle(3);
    check_eq("idle_flush_none", bus.out_valid, 0);

    // flush in IDLE with a sample: 1-sample block
    cyc(1, 1, -77, 0);
    idle(LAT - 1);
    cyc(1, 0, 0, 1);
    check_eq("flush1_sum", bus.out_data, -77);
    check_eq("flush1_len", bus.out_len, 1);
    drain();

    // backpressure: third block lost
    bus.out_ready = 1'b0;
    blk(10);
    blk(200);
    skip_push = 1'b1;
    blk(3000);
    check_eq("bp_drop", bus.drop, 1);
    check_eq("bp_depth", exp_data.size(), 2);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", bus.out_valid, 1);
      check_eq("bp_hold", bus.out_data, (exp_data.size() > 0) ? exp_data[0] : 0);
      idle(1);
    end
    check_eq("bp_first", (exp_data.size() > 0) ? exp_data[0] : 0, 46);
    bus.out_ready = 1'b1;
    drain();

    // overflow
    blk_ovf: begin
      for (int j = 0; j < BL; j++) cyc(1, 1, 1048575, 0);
      idle(LAT);
    end
    check_eq("ovf_flag", bus.ovf, 1);
`ifdef BLOCK_ACC_SATURATE_EN
    check_eq("ovf_sum", bus.out_data, 2097151);
`else
    check_eq("ovf_sum", bus.out_data, -4);
`endif
    drain();

    // asynchronous reset mid-block
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    idle(LAT);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", bus.out_valid, 0);
    check_eq("arst_data", bus.out_data, 0);
    check_eq("arst_drop", bus.drop, 0);
    check_eq("arst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    exp_data.delete();
    exp_len.delete();
    @(posedge clk);
    #1;
    blk(1);
    check_eq("arst_fresh_sum", bus.out_data, 4 + 6);
    drain();

    // ones block after reset
    for (int j = 0; j < BL; j++) cyc(1, 1, 1, 0);
    idle(LAT);
    check_eq("ones_sum", bus.out_data, 4);
    check_eq("ones_len", bus.out_len, 4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
